// File: rtl/pipe_step_ctrl_if.sv
// Handshake and control bundle between the step sequencer, the front panel and the LCD refresh.
// The slave modport is the sequencer's view; the master modport is the view of whoever drives it.
interface pipe_step_ctrl_if #(
  parameter int unsigned CntW = 8
) ();

  logic            step_req;
  logic            run_req;
  logic [CntW-1:0] run_cnt;
  logic            brk_en;
  logic [31:0]     brk_pc;
  logic [31:0]     pc;
  logic            upd_ack;

  logic            step_en;
  logic            upd_req;
  logic            busy;
  logic            halted;
  logic [CntW-1:0] cycle_cnt;

  modport master (
    output step_req,
    output run_req,
    output run_cnt,
    output brk_en,
    output brk_pc,
    output pc,
    output upd_ack,
    input  step_en,
    input  upd_req,
    input  busy,
    input  halted,
    input  cycle_cnt
  );

  modport slave (
    input  step_req,
    input  run_req,
    input  run_cnt,
    input  brk_en,
    input  brk_pc,
    input  pc,
    input  upd_ack,
    output step_en,
    output upd_req,
    output busy,
    output halted,
    output cycle_cnt
  );

endinterface

// File: rtl/pipe_step_ctrl.sv
// Step sequencer for the 5-stage CPU: turns step/run buttons into one-cycle step_en pulses,
// interlocked with the LCD refresh handshake, with burst, free-run and PC breakpoint support.
module pipe_step_ctrl #(
  parameter int unsigned CntW   = 8,
  parameter int unsigned GapW   = 16,
  parameter int unsigned RunGap = 25000
) (
  input logic             clk_i,
  input logic             rst_ni,
  pipe_step_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StWaitAck,
    StGap
  } state_e;

  localparam logic [GapW-1:0] GapLoad = GapW'(RunGap - 1);

  state_e state_q, state_d;

  logic            step_prev_q;
  logic            run_prev_q;
  logic [CntW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CntW-1:0] remaining_q, remaining_d;
  logic            free_q, free_d;
  logic            abort_q, abort_d;
  logic            halted_q, halted_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic step_rise;
  logic run_rise;
  logic abort_now;
  logic brk_hit;
  logic burst_done;

  assign step_rise  = bus_io.step_req & ~step_prev_q;
  assign run_rise   = bus_io.run_req & ~run_prev_q;
  // A run edge arriving on the very cycle it matters counts as an abort already.
  assign abort_now  = abort_q | run_rise;
  assign brk_hit    = bus_io.brk_en && (bus_io.pc == bus_io.brk_pc);
  assign burst_done = !free_q && (remaining_q == '0);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      step_prev_q <= 1'b0;
      run_prev_q  <= 1'b0;
      cycle_cnt_q <= '0;
      remaining_q <= '0;
      free_q      <= 1'b0;
      abort_q     <= 1'b0;
      halted_q    <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_prev_q <= bus_io.step_req;
      run_prev_q  <= bus_io.run_req;
      cycle_cnt_q <= cycle_cnt_d;
      remaining_q <= remaining_d;
      free_q      <= free_d;
      abort_q     <= abort_d;
      halted_q    <= halted_d;
      gap_q       <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run_rise || step_rise) begin
          state_d = StStep;
        end
      end
      StStep: begin
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (bus_io.upd_ack) begin
          state_d = (abort_now || brk_hit || burst_done) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (abort_now) begin
          state_d = StIdle;
        end else if (gap_q == '0) begin
          state_d = StStep;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: counters, run mode and status flags
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    remaining_d = remaining_q;
    free_d      = free_q;
    abort_d     = abort_q;
    halted_d    = halted_q;
    gap_d       = gap_q;

    unique case (state_q)
      StIdle: begin
        if (run_rise) begin
          remaining_d = bus_io.run_cnt;
          free_d      = (bus_io.run_cnt == '0);
          halted_d    = 1'b0;
        end else if (step_rise) begin
          remaining_d = CntW'(1);
          free_d      = 1'b0;
          halted_d    = 1'b0;
        end
      end
      StStep: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (!free_q) begin
          remaining_d = remaining_q - 1'b1;
        end
        if (run_rise) begin
          abort_d = 1'b1;
        end
      end
      StWaitAck: begin
        if (run_rise) begin
          abort_d = 1'b1;
        end
        if (bus_io.upd_ack) begin
          if (!abort_now && brk_hit) begin
            halted_d = 1'b1;
          end else if (!abort_now && !burst_done) begin
            gap_d = GapLoad;
          end
        end
      end
      StGap: begin
        if (run_rise) begin
          abort_d = 1'b1;
        end
        if (!abort_now && (gap_q != '0)) begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (state_d == StIdle) begin
      abort_d = 1'b0;
    end
  end

  // Outputs decode straight from state so reset drops upd_req asynchronously
  always_comb begin
    bus_io.step_en   = 1'b0;
    bus_io.upd_req   = 1'b0;
    bus_io.busy      = 1'b1;
    bus_io.halted    = halted_q;
    bus_io.cycle_cnt = cycle_cnt_q;
    unique case (state_q)
      StIdle:    bus_io.busy    = 1'b0;
      StStep:    bus_io.step_en = 1'b1;
      StWaitAck: bus_io.upd_req = 1'b1;
      StGap:     ;
      default:   ;
    endcase
  end

  step_not_during_req_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus_io.step_en |-> !bus_io.upd_req
  );

  step_single_cycle_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus_io.step_en |=> !bus_io.step_en
  );

  req_follows_step_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) $rose(bus_io.upd_req) |-> $past(bus_io.step_en)
  );

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl: a timestamp-based run model checked every cycle,
// plus literal expectations for each scenario.
module tb_pipe_step_ctrl;

  localparam int unsigned CntW   = 8;
  localparam int unsigned GapW   = 16;
  localparam int unsigned RunGap = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_step_ctrl_if #(.CntW(CntW)) bus ();

  pipe_step_ctrl #(
    .CntW  (CntW),
    .GapW  (GapW),
    .RunGap(RunGap)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step log and PC generator: pc = 4 * steps since pc_base was taken
  int se_count = 0;
  int se_times[$];
  int pc_base  = 0;
  assign bus.pc = 32'((se_count - pc_base) * 4);

  // Model: a run is a sequence of scheduled step cycles, each followed by a display wait
  int m_cyc       = 0;
  int m_next_step = -1;
  int m_left      = 0;   // -1 = free-run
  bit m_active    = 0;
  bit m_waiting   = 0;
  bit m_abort     = 0;
  bit m_halted    = 0;
  int m_cnt       = 0;
  bit m_step_prev = 0;
  bit m_run_prev  = 0;
  bit m_sr, m_rr, m_end;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_next_step = -1;
      m_left      = 0;
      m_active    = 0;
      m_waiting   = 0;
      m_abort     = 0;
      m_halted    = 0;
      m_cnt       = 0;
      m_step_prev = 0;
      m_run_prev  = 0;
    end else begin
      m_sr        = bus.step_req && !m_step_prev;
      m_rr        = bus.run_req && !m_run_prev;
      m_step_prev = bus.step_req;
      m_run_prev  = bus.run_req;
      m_end       = 0;
      if (!m_active) begin
        if (m_rr || m_sr) begin
          m_left      = m_rr ? ((bus.run_cnt == 0) ? -1 : int'(bus.run_cnt)) : 1;
          m_halted    = 0;
          m_active    = 1;
          m_next_step = m_cyc + 1;
        end
      end else if (m_next_step == m_cyc) begin
        m_cnt       = (m_cnt + 1) % 256;
        if (m_left > 0) m_left--;
        m_waiting   = 1;
        m_next_step = -1;
        if (m_rr) m_abort = 1;
      end else if (m_waiting) begin
        if (m_rr) m_abort = 1;
        if (bus.upd_ack) begin
          m_waiting = 0;
          if (m_abort) m_end = 1;
          else if (bus.brk_en && bus.pc == bus.brk_pc) begin
            m_halted = 1;
            m_end    = 1;
          end else if (m_left == 0) m_end = 1;
          else m_next_step = m_cyc + RunGap + 1;
        end
      end else if (m_rr) begin
        m_end = 1;
      end
      if (m_end) begin
        m_active    = 0;
        m_abort     = 0;
        m_next_step = -1;
      end
      m_cyc++;
    end
  end

  // Per-cycle compare against the model, mid-cycle
  initial forever begin
    @(negedge clk);
    check("step_en", bus.step_en, (m_active && m_next_step == m_cyc) ? 1 : 0);
    check("upd_req", bus.upd_req, m_waiting);
    check("busy", bus.busy, m_active);
    check("halted", bus.halted, m_halted);
    check("cycle_cnt", bus.cycle_cnt, m_cnt);
    if (bus.step_en === 1'b1) begin
      se_count++;
      se_times.push_back(m_cyc);
    end
  end

  // LCD responder: acks once upd_req has been high for AckDly cycles
  localparam int AckDly = 3;
  bit auto_ack = 1;
  int req_age  = 0;
  initial begin
    bus.upd_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.upd_req === 1'b1) req_age++;
      else req_age = 0;
      bus.upd_ack = auto_ack && (req_age >= AckDly);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (bus.busy && i < budget) begin
      tick(1);
      i++;
    end
    check(name, bus.busy, 0);
  endtask

  task automatic wait_req(input string name, input logic lvl, input int budget);
    int i = 0;
    while (bus.upd_req !== lvl && i < budget) begin
      tick(1);
      i++;
    end
    check(name, bus.upd_req, lvl);
  endtask

  task automatic pulse_run(input logic [CntW-1:0] cnt);
    bus.run_cnt = cnt;
    bus.run_req = 1'b1;
    tick(1);
    bus.run_req = 1'b0;
  endtask

  int base;

  initial begin
    bus.step_req = 1'b0;
    bus.run_req  = 1'b0;
    bus.run_cnt  = '0;
    bus.brk_en   = 1'b0;
    bus.brk_pc   = '0;

    // T1: reset state, one single step
    tick(3);
    check("rst_step_en", bus.step_en, 0);
    check("rst_upd_req", bus.upd_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_cycle_cnt", bus.cycle_cnt, 0);
    rst_n = 1'b1;
    tick(2);
    bus.step_req = 1'b1;
    tick(1);
    check("t1_step_en", bus.step_en, 1);
    bus.step_req = 1'b0;
    tick(1);
    check("t1_upd_req", bus.upd_req, 1);
    check("t1_cycle_cnt", bus.cycle_cnt, 1);
    wait_idle("t1_idle", 20);

    // T2: held button gives one step; edge while awaiting ack is ignored
    auto_ack = 0;
    base = se_count;
    bus.step_req = 1'b1;
    tick(100);
    check("t2_one_step", se_count - base, 1);
    check("t2_upd_req_held", bus.upd_req, 1);
    bus.step_req = 1'b0;
    tick(2);
    bus.step_req = 1'b1;
    tick(3);
    check("t2_ignored_cnt", bus.cycle_cnt, 2);
    check("t2_ignored_steps", se_count - base, 1);
    bus.step_req = 1'b0;
    auto_ack = 1;
    wait_idle("t2_idle", 20);

    // T3: burst of 3, 8 cycles between steps
    base = se_count;
    pulse_run(8'd3);
    wait_idle("t3_idle", 200);
    check("t3_steps", se_count - base, 3);
    check("t3_gap01", se_times[base+1] - se_times[base], 8);
    check("t3_gap12", se_times[base+2] - se_times[base+1], 8);
    check("t3_cycle_cnt", bus.cycle_cnt, 5);
    check("t3_halted", bus.halted, 0);

    // T4: free-run to breakpoint at pc 0x0C
    base = se_count;
    pc_base = se_count;
    bus.brk_en = 1'b1;
    bus.brk_pc = 32'h0000_000C;
    pulse_run(8'd0);
    wait_idle("t4_idle", 300);
    check("t4_steps", se_count - base, 3);
    check("t4_halted", bus.halted, 1);
    check("t4_cycle_cnt", bus.cycle_cnt, 8);
    bus.brk_en = 1'b0;

    // T5a: abort during GAP
    base = se_count;
    pulse_run(8'd0);
    wait_req("t5a_req_up", 1'b1, 20);
    wait_req("t5a_req_down", 1'b0, 20);
    bus.run_req = 1'b1;
    tick(1);
    check("t5a_busy", bus.busy, 0);
    check("t5a_halted_cleared", bus.halted, 0);
    tick(20);
    check("t5a_steps", se_count - base, 1);
    bus.run_req = 1'b0;
    tick(2);

    // T5b: abort during WAIT_ACK
    base = se_count;
    pulse_run(8'd0);
    wait_req("t5b_req_up", 1'b1, 20);
    bus.run_req = 1'b1;
    tick(1);
    bus.run_req = 1'b0;
    wait_req("t5b_req_down", 1'b0, 20);
    check("t5b_busy", bus.busy, 0);
    tick(20);
    check("t5b_steps", se_count - base, 1);
    check("t5b_cycle_cnt", bus.cycle_cnt, 10);

    // T6a: cycle counter wrap
    base = se_count;
    pulse_run(8'd245);
    wait_idle("t6a_burst_idle", 5000);
    check("t6a_burst_steps", se_count - base, 245);
    check("t6a_cnt_255", bus.cycle_cnt, 255);
    bus.step_req = 1'b1;
    tick(1);
    bus.step_req = 1'b0;
    wait_idle("t6a_idle", 20);
    check("t6a_cnt_wrap", bus.cycle_cnt, 0);

    // T6b: async reset while awaiting ack
    pulse_run(8'd0);
    wait_req("t6b_req_up", 1'b1, 20);
    rst_n = 1'b0;
    #1;
    check("t6b_upd_req_async", bus.upd_req, 0);
    check("t6b_busy_async", bus.busy, 0);
    check("t6b_cnt_async", bus.cycle_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    base = se_count;
    tick(10);
    check("t6b_no_step", se_count - base, 0);
    check("t6b_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
